// File: rtl/ram_stream_pkg.sv
// Shared types and helpers for the RAM read streamer and its output FIFO.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int AW_DEF = 11;
  localparam int MW_DEF = 8;
  localparam int DW_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO; dout is the head entry, storage clears on reset so
// dout reads zero while empty after reset.
module stream_fifo
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [clog2(DEPTH):0]    count
);

  localparam int PW = clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop && (r_count != '0);
  // a push into a full FIFO is only legal when the head leaves on the same edge
  assign w_push = push && ((r_count != FULL) || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign valid = (r_count != '0);
  assign count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(push && (r_count == FULL) && !pop));

endmodule

// File: rtl/ram_read_streamer.sv
// Walks a strided address range on a 1-cycle-latency RAM port and streams the
// returned words out through a credit-checked FIFO.
module ram_read_streamer
  import ram_stream_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int MW         = MW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [AW-1:0]     start_addr,
  input  logic [AW-1:0]     stride,
  input  logic [AW:0]       count,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     ram_addr,
  output logic [MW-1:0]     ram_we,
  output logic [MW*DW-1:0]  ram_d,
  input  logic [MW*DW-1:0]  ram_q,
  output logic [MW*DW-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int          CW      = clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] REM_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_stride;
  logic [AW:0]     r_remaining;
  logic            r_rd_pending;
  logic            r_done;
  logic            w_done_nxt;
  logic [CW-1:0]   w_fifo_count;
  logic [CW:0]     w_credit;
  logic            w_issue;
  logic            w_pop;
  logic            w_load;

  // in-flight read counts against FIFO space so the push can never overflow
  assign w_credit = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_rd_pending};
  assign w_issue  = (r_state == RUN) && (w_credit < DEPTH_L);
  assign w_pop    = out_valid && out_ready;
  assign w_load   = (r_state == IDLE) && start && (count != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (count != '0) w_state_nxt = RUN;
          else             w_done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (w_issue && (r_remaining == REM_ONE)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_rd_pending && (w_fifo_count == CNT_ONE) && w_pop) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != IDLE);
    done     = r_done;
    ram_addr = r_addr;
    ram_we   = '0;
    ram_d    = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr       <= '0;
      r_stride     <= '0;
      r_remaining  <= '0;
      r_rd_pending <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done       <= w_done_nxt;
      r_rd_pending <= w_issue;
      if (w_load) begin
        r_addr      <= start_addr;
        r_stride    <= stride;
        r_remaining <= count;
      end else if (w_issue) begin
        r_addr      <= r_addr + r_stride;
        r_remaining <= r_remaining - REM_ONE;
      end
    end
  end

  stream_fifo #(
    .WIDTH (MW*DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (r_rd_pending),
    .din    (ram_q),
    .pop    (w_pop),
    .dout   (out_data),
    .valid  (out_valid),
    .count  (w_fifo_count)
  );

endmodule

// File: tb/tb_ram_read_streamer.sv
// Directed bench for ram_read_streamer with a 1-cycle-latency RAM model.
module tb_ram_read_streamer;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [10:0] start_addr;
  logic [10:0] stride;
  logic [11:0] count;
  logic        busy;
  logic        done;
  logic [10:0] ram_addr;
  logic [7:0]  ram_we;
  logic [63:0] ram_d;
  logic [63:0] ram_q;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [63:0] mem [2048];
  logic [63:0] rx_q [$];
  int          rx_cyc [$];
  int          cyc;
  int          done_cnt;
  int          done_cyc;
  logic        busy_at_done;
  logic        valid_seen;
  int          we_bad;
  int          n_cmp;
  int          n_err;

  ram_read_streamer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .start_addr (start_addr),
    .stride     (stride),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_d      (ram_d),
    .ram_q      (ram_q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_q <= mem[ram_addr];

  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        rx_cyc.push_back(cyc);
      end
      if (out_valid) valid_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (ram_we != '0 || ram_d != '0) we_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [10:0] sa, input logic [10:0] st,
                          input logic [11:0] n, output int s);
    start_addr = sa;
    stride     = st;
    count      = n;
    start      = 1'b1;
    @(posedge clk);
    #1;
    s     = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    chk(tag, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic check_stream(input string tag, input int base, input logic [10:0] sa,
                              input logic [10:0] st, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a = (int'(sa) + i * int'(st)) % 2048;
      chk($sformatf("%s_b%0d", tag, i), rx_q[base+i], mem[a]);
    end
  endtask

  initial begin
    int s, s2, dummy, d0;
    cyc = 0; done_cnt = 0; done_cyc = 0; busy_at_done = 1'b0;
    valid_seen = 1'b0; we_bad = 0; n_cmp = 0; n_err = 0;
    for (int i = 0; i < 2048; i++)
      mem[i] = 64'h5A00_0000_0000_0000 ^ (64'(i) * 64'h0001_0003_0007_000F);
    mem[16'h10] = 64'hAAAA_AAAA_0000_000A;
    mem[16'h11] = 64'hBBBB_BBBB_0000_000B;
    mem[16'h12] = 64'hCCCC_CCCC_0000_000C;
    mem[16'h13] = 64'hDDDD_DDDD_0000_000D;
    start = 1'b0; start_addr = '0; stride = '0; count = '0; out_ready = 1'b1;
    resetn = 1'b0;

    // reset values
    tick(); tick();
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  out_data,       64'd0);
    chk("rst_addr",  64'(ram_addr),  64'd0);
    chk("rst_we",    64'(ram_we),    64'd0);
    chk("rst_d",     ram_d,          64'd0);
    resetn = 1'b1;
    tick();

    // basic stream: A,B,C,D back to back, first beat 2 cycles after start
    rx_q.delete(); rx_cyc.delete();
    do_start(11'h010, 11'd1, 12'd4, s);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_addr", 64'(ram_addr), 64'h010);
    wait_done("t1_done");
    chk("t1_n", 64'(rx_q.size()), 64'd4);
    chk("t1_A", rx_q[0], 64'hAAAA_AAAA_0000_000A);
    chk("t1_B", rx_q[1], 64'hBBBB_BBBB_0000_000B);
    chk("t1_C", rx_q[2], 64'hCCCC_CCCC_0000_000C);
    chk("t1_D", rx_q[3], 64'hDDDD_DDDD_0000_000D);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_cyc%0d", i), 64'(rx_cyc[i] - s), 64'(2 + i));
    chk("t1_done_cyc", 64'(done_cyc - s), 64'd6);
    chk("t1_busy_at_done", 64'(busy_at_done), 64'd0);

    // backpressure: ready low in cycles 3..11, FIFO fills to exactly DEPTH
    rx_q.delete(); rx_cyc.delete();
    do_start(11'h100, 11'd1, 12'd8, s);
    tick(); tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t2_rx_stall", 64'(rx_q.size()), 64'd1);
    chk("t2_addr_stall", 64'(ram_addr), 64'h105);
    chk("t2_busy_stall", 64'(busy), 64'd1);
    tick();
    out_ready = 1'b1;
    wait_done("t2_done");
    chk("t2_n", 64'(rx_q.size()), 64'd8);
    check_stream("t2", 0, 11'h100, 11'd1, 8);

    // address wrap and non-unit stride
    rx_q.delete(); rx_cyc.delete();
    do_start(11'h7FE, 11'd1, 12'd4, s);
    wait_done("t3a_done");
    chk("t3a_n", 64'(rx_q.size()), 64'd4);
    check_stream("t3a", 0, 11'h7FE, 11'd1, 4);
    chk("t3a_b2_is_0", rx_q[2], mem[0]);
    rx_q.delete(); rx_cyc.delete();
    do_start(11'h005, 11'd3, 12'd3, s);
    wait_done("t3b_done");
    chk("t3b_n", 64'(rx_q.size()), 64'd3);
    chk("t3b_b2_is_0B", rx_q[2], mem[11'h00B]);
    check_stream("t3b", 0, 11'h005, 11'd3, 3);

    // zero count: immediate done, nothing read or delivered
    rx_q.delete(); rx_cyc.delete(); valid_seen = 1'b0;
    d0 = done_cnt;
    do_start(11'h020, 11'd1, 12'd0, s);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    tick();
    chk("t4_done_off", 64'(done), 64'd0);
    tick(); tick();
    chk("t4_valid_seen", 64'(valid_seen), 64'd0);
    chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

    // start while busy is ignored
    rx_q.delete(); rx_cyc.delete();
    do_start(11'h200, 11'd1, 12'd6, s);
    tick(); tick();
    do_start(11'h300, 11'd5, 12'd2, dummy);
    wait_done("t4b_done");
    chk("t4b_n", 64'(rx_q.size()), 64'd6);
    check_stream("t4b", 0, 11'h200, 11'd1, 6);

    // reset mid-transfer with two beats queued
    rx_q.delete(); rx_cyc.delete();
    out_ready = 1'b0;
    do_start(11'h400, 11'd1, 12'd8, s);
    tick(); tick(); tick();
    chk("t5_valid_pre", 64'(out_valid), 64'd1);
    d0 = done_cnt;
    resetn = 1'b0;
    #1;
    chk("t5_busy",  64'(busy),      64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_data",  out_data,       64'd0);
    chk("t5_addr",  64'(ram_addr),  64'd0);
    chk("t5_done",  64'(done),      64'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    out_ready = 1'b1;
    rx_q.delete(); rx_cyc.delete();
    do_start(11'h480, 11'd1, 12'd2, s);
    wait_done("t5_done2");
    chk("t5_n", 64'(rx_q.size()), 64'd2);
    check_stream("t5", 0, 11'h480, 11'd1, 2);

    // back-to-back: restart in the done cycle
    rx_q.delete(); rx_cyc.delete();
    do_start(11'h500, 11'd2, 12'd3, s);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      tick();
    end
    chk("t6_done_seen", 64'(done), 64'd1);
    do_start(11'h600, 11'd1, 12'd2, s2);
    chk("t6_busy2", 64'(busy), 64'd1);
    wait_done("t6_done2");
    chk("t6_n", 64'(rx_q.size()), 64'd5);
    check_stream("t6a", 0, 11'h500, 11'd2, 3);
    check_stream("t6b", 3, 11'h600, 11'd1, 2);
    chk("t6_lat", 64'(rx_cyc[3] - s2), 64'd2);

    chk("we_never", 64'(we_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
